// File: rtl/if_fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_buffer
// Brief    : Credit-based instruction fetch requester with a DEPTH-entry
//            instruction/PC buffer, redirect flush and optional halt detection
//            (enabled by defining IF_HALT_DETECT_EN).
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch_buffer #(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] HALT_PC = 32'd248
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_i,
  input  logic        pc_valid_i,
  output logic        pc_ready_o,
  input  logic        flush_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic        halt_o
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam int              c_CW      = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
  localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
  localparam logic [c_AW-1:0] c_PTR_ONE = c_AW'(1);

  logic [31:0]     r_fifo_data [DEPTH];
  logic [31:0]     r_fifo_pc   [DEPTH];
  logic [31:0]     r_pend_pc   [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW-1:0] r_pend_wr;
  logic [c_AW-1:0] r_pend_rd;
  logic [c_CW-1:0] r_count;
  logic [c_CW-1:0] r_inflight;
  logic [c_CW-1:0] r_discard;

  logic w_halted;
  logic w_credit;
  logic w_req;
  logic w_accept;
  logic w_rsp;
  logic w_drop;
  logic w_push;
  logic w_valid;
  logic w_pop;

  // Credit counts discarded in-flight fetches too, so the buffer can never overflow.
  always_comb begin
    w_credit = (r_inflight + r_count) < c_DEPTH;
    w_req    = ~rst_i & pc_valid_i & w_credit & ~flush_i & ~w_halted;
    w_accept = w_req & imem_gnt_i;
    w_rsp    = imem_rvalid_i & (r_inflight != '0);
    w_drop   = w_rsp & (flush_i | (r_discard != '0));
    w_push   = w_rsp & ~w_drop;
    w_valid  = (r_count != '0);
    w_pop    = w_valid & inst_ready_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_pend_wr  <= '0;
      r_pend_rd  <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      if (w_accept) r_pend_wr <= r_pend_wr + c_PTR_ONE;
      if (w_rsp)    r_pend_rd <= r_pend_rd + c_PTR_ONE;
      case ({w_accept, w_rsp})
        2'b10:   r_inflight <= r_inflight + c_CNT_ONE;
        2'b01:   r_inflight <= r_inflight - c_CNT_ONE;
        default: r_inflight <= r_inflight;
      endcase
      if (flush_i) begin
        // Everything still outstanding after this cycle's response is stale.
        r_wr_ptr  <= '0;
        r_rd_ptr  <= '0;
        r_count   <= '0;
        r_discard <= r_inflight - {{c_AW{1'b0}}, w_rsp};
      end else begin
        if (w_drop) r_discard <= r_discard - c_CNT_ONE;
        if (w_push) r_wr_ptr  <= r_wr_ptr + c_PTR_ONE;
        if (w_pop)  r_rd_ptr  <= r_rd_ptr + c_PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_accept) r_pend_pc[r_pend_wr] <= pc_i;
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rdata_i;
      r_fifo_pc[r_wr_ptr]   <= r_pend_pc[r_pend_rd];
    end
  end

`ifdef IF_HALT_DETECT_EN
  logic r_halted;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_halted <= 1'b0;
    end else if (flush_i) begin
      r_halted <= 1'b0;
    end else if (w_accept && (pc_i == HALT_PC)) begin
      r_halted <= 1'b1;
    end
  end

  assign w_halted = r_halted;
`else
  logic w_halt_pc_unused;

  assign w_halted         = 1'b0;
  assign w_halt_pc_unused = ^HALT_PC;
`endif

  assign imem_req_o   = w_req;
  assign imem_addr_o  = pc_i;
  assign pc_ready_o   = w_accept;
  assign inst_valid_o = w_valid;
  assign inst_o       = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign inst_pc_o    = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign halt_o       = w_halted;

`ifndef SYNTHESIS
  // A response with nothing outstanding is a memory protocol violation.
  always_ff @(posedge clk_i) begin
    if (!rst_i && imem_rvalid_i) assert (r_inflight != '0);
  end
`endif

endmodule
`default_nettype wire

// File: doc/if_fetch_buffer.md
Name: if_fetch_buffer

Overview:
- Instruction-fetch reader on the consumer side of the PC register: takes the fetch address the PC presents, issues read requests to instruction memory, and buffers returned words with their PCs for decode.
- Provides the backpressure that drives the PC hazard/stall input.
- Supports pipeline flush on redirect, and optionally halt detection at the terminal fetch address.

Parameters:
- DEPTH, 4, instruction FIFO entries; power of two, >= 2
- HALT_PC, 32'd248, fetch address that marks end of program (used only with IF_HALT_DETECT_EN)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- pc_i  in  32  fetch address from PC
- pc_valid_i  in  1  pc_i is valid this cycle
- pc_ready_o  out  1  fetch of pc_i accepted this cycle; PC advances only when high (inverse feeds PC hazard input)
- flush_i  in  1  redirect: discard all buffered and in-flight fetches
- imem_req_o  out  1  memory read request
- imem_addr_o  out  32  request address (= pc_i)
- imem_gnt_i  in  1  memory accepts request this cycle
- imem_rvalid_i  in  1  read data valid; in-order, exactly one per granted request, >= 1 cycle after grant
- imem_rdata_i  in  32  read data
- inst_o  out  32  instruction at FIFO head
- inst_pc_o  out  32  PC of instruction at FIFO head
- inst_valid_o  out  1  FIFO non-empty
- inst_ready_i  in  1  decode consumes head this cycle
- halt_o  out  1  halt address fetched (sticky)

Behaviour:
- Reset (rst_i high, async): FIFO empty, in-flight count 0, discard count 0, halted 0; outputs inst_valid_o=0, inst_o=0, inst_pc_o=0, imem_req_o=0, pc_ready_o=0, halt_o=0. Reset mid-transfer drops everything; responses to pre-reset grants are not expected by the bench.
- Credit rule: inflight (granted, not yet returned, including to-be-discarded) + FIFO occupancy < DEPTH.
- imem_req_o = pc_valid_i & credit & ~flush_i & ~halted (combinational); imem_addr_o = pc_i.
- Accept = imem_req_o & imem_gnt_i; pc_ready_o = accept. Accepted PC pushed into an internal DEPTH-entry pending-PC queue.
- Response: on imem_rvalid_i, if discard count > 0, decrement and drop (pop pending PC); else write {imem_rdata_i, pending PC} to FIFO tail. Visible at inst_o the cycle after rvalid (1-cycle latency, registered).
- Consume: inst_valid_o & inst_ready_i pops head. Push and pop in the same cycle are both performed; occupancy unchanged. Pop of empty FIFO ignored.
- Credit is freed the cycle after pop, so at full occupancy a same-cycle pop does not enable a same-cycle request.
- Flush (flush_i high for a cycle): no request that cycle; FIFO cleared next edge; discard count <= inflight minus any response arriving that cycle (that response is dropped); pending-PC queue kept for discard pops; halted cleared. inst_valid_o = 0 the cycle after flush.
- Flush while discard count is already nonzero accumulates correctly (new discard = all in-flight).
- Counters sized $clog2(DEPTH)+1; never wrap by construction; rvalid with inflight 0 is a protocol error (ignored, assertion under simulation).

Optional Feature:
- IF_HALT_DETECT_EN defined: accept with pc_i == HALT_PC sets halted/halt_o next cycle (sticky until flush or reset); no further requests while halted; already-fetched instructions still drain.
- Undefined: halt_o tied 0; HALT_PC unused; fetching never stops on address.

Test Plan:
- Reset then pc_valid_i=1, pc_i=0,4,8, gnt=1, rvalid 1 cycle later with data A,B,C -> inst_o A/B/C with inst_pc_o 0/4/8, each 1 cycle after its rvalid.
- inst_ready_i=0, DEPTH=4, gnt always 1 -> exactly 4 accepts, then pc_ready_o=0, imem_req_o=0 until a pop.
- 2 requests in flight, flush_i pulse, then request pc_i=0x40 -> both old responses dropped, only 0x40 data appears with inst_pc_o=0x40.
- Flush in the same cycle as an rvalid with the FIFO holding 2 entries -> inst_valid_o=0 next cycle; that response never appears.
- With IF_HALT_DETECT_EN, fetch 240,244,248 -> halt_o=1 cycle after 248 accepted, no request for 252, 3 instructions drain.
- rst_i asserted mid-stream with the FIFO at 3 -> all outputs 0 immediately (async), before the next clock edge.
